// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the load/store data memory:
// funct3 codes, FSM states, byte-enable and legality helpers.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } mem_state_e;

    function automatic logic [3:0] lane_mask(
        input logic [2:0] funct3,
        input logic [1:0] off
    );
        logic [3:0] m;
        m = 4'b0000;
        case (funct3)
            F3_B, F3_BU: m = 4'b0001 << off;
            F3_H, F3_HU: m = off[1] ? 4'b1100 : 4'b0011;
            F3_W:        m = 4'b1111;
            default:     m = 4'b0000;
        endcase
        return m;
    endfunction

    // Unsigned variants exist only for loads.
    function automatic logic is_legal(
        input logic       write,
        input logic [2:0] funct3,
        input logic [1:0] off
    );
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = ~write;
            F3_HU:   ok = ~write & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Write-data lane replication and load shift / extension
// between the 32-bit lane word and the LSB-aligned core view.
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] wlanes,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    assign shifted = rword >> {offset, 3'b000};

    // Replicate so the byte enables alone pick the lanes.
    always_comb begin
        wlanes = wdata;
        case (funct3)
            F3_B, F3_BU: wlanes = {4{wdata[7:0]}};
            F3_H, F3_HU: wlanes = {2{wdata[15:0]}};
            default:     wlanes = wdata;
        endcase
    end

    always_comb begin
        rdata = 32'h0;
        case (funct3)
            F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   rdata = {24'h0, shifted[7:0]};
            F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   rdata = {16'h0, shifted[15:0]};
            F3_W:    rdata = rword;
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/riscv_data_mem.sv
// Byte-addressable data memory with one outstanding request
// and a fixed, configurable response latency.
module riscv_data_mem
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_WIDTH  = $clog2(DEPTH_BYTES),
    parameter int LATENCY     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_fault
);

    localparam int WORDS = DEPTH_BYTES / 4;
    localparam logic [1:0] LAT_M1 = 2'(LATENCY - 1);

    logic [7:0] mem [4][WORDS];

    mem_state_e state, state_n;
    logic [1:0] cnt, cnt_n;
    logic       ready_en;

    logic [31:0] pend_rdata;
    logic        pend_fault;

    logic                  accept;
    logic                  legal;
    logic [1:0]            off;
    logic [ADDR_WIDTH-3:0] widx;
    logic [3:0]            be;
    logic [31:0]           rword;
    logic [31:0]           wlanes;
    logic [31:0]           ld_data;
    logic [31:0]           new_rdata;
    logic                  new_fault;
    logic                  load_rsp;

    assign off   = req_addr[1:0];
    assign widx  = req_addr[ADDR_WIDTH-1:2];
    assign legal = is_legal(req_write, req_funct3, off);

    // Ready again in the response cycle so LATENCY=1 streams.
    assign req_ready = ready_en && !reset && (cnt == 2'd0);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == S_WAIT) && (cnt == 2'd0);

    assign be = (legal && req_write)
              ? lane_mask(req_funct3, off) : 4'b0000;

    assign rword = {mem[3][widx], mem[2][widx],
                    mem[1][widx], mem[0][widx]};

    mem_lane_align u_align (
        .funct3 (req_funct3),
        .offset (off),
        .wdata  (req_wdata),
        .rword  (rword),
        .wlanes (wlanes),
        .rdata  (ld_data)
    );

    assign new_rdata = (legal && !req_write) ? ld_data : 32'h0;
    assign new_fault = !legal;

    // Output registers update only on the edge entering a response.
    assign load_rsp = (accept && LATENCY == 1)
                   || (state == S_WAIT && cnt == 2'd1);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_WAIT;
                    cnt_n   = LAT_M1;
                end
            end
            S_WAIT: begin
                if (accept) begin
                    state_n = S_WAIT;
                    cnt_n   = LAT_M1;
                end else if (cnt == 2'd0) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt - 2'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 2'd0;
            ready_en   <= 1'b0;
            pend_rdata <= 32'h0;
            pend_fault <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_fault  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            ready_en <= 1'b1;
            if (accept) begin
                pend_rdata <= new_rdata;
                pend_fault <= new_fault;
            end
            if (load_rsp) begin
                rsp_rdata <= accept ? new_rdata : pend_rdata;
                rsp_fault <= accept ? new_fault : pend_fault;
            end
        end
    end

    // Storage is never reset; accept already excludes reset.
    always_ff @(posedge clock) begin
        for (int l = 0; l < 4; l++) begin
            if (accept && be[l]) begin
                mem[l][widx] <= wlanes[8*l +: 8];
            end
        end
    end

endmodule

// File: tb/tb_riscv_data_mem.sv
// Table-driven scoreboard bench: LATENCY=1 functional vectors
// plus LATENCY=3 handshake and mid-operation reset sequences.
module tb_riscv_data_mem;
    import riscv_mem_pkg::*;

    localparam int AW = 10;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset1, v1, w1, rdy1, rv1, flt1;
    logic [2:0]    f1;
    logic [AW-1:0] a1;
    logic [31:0]   wd1, rd1;

    logic          reset3, v3, w3, rdy3, rv3, flt3;
    logic [2:0]    f3;
    logic [AW-1:0] a3;
    logic [31:0]   wd3, rd3;

    riscv_data_mem #(.DEPTH_BYTES(1024), .LATENCY(1)) dut1 (
        .clock(clock), .reset(reset1),
        .req_valid(v1), .req_ready(rdy1), .req_write(w1),
        .req_funct3(f1), .req_addr(a1), .req_wdata(wd1),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_fault(flt1)
    );

    riscv_data_mem #(.DEPTH_BYTES(1024), .LATENCY(3)) dut3 (
        .clock(clock), .reset(reset3),
        .req_valid(v3), .req_ready(rdy3), .req_write(w3),
        .req_funct3(f3), .req_addr(a3), .req_wdata(wd3),
        .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_fault(flt3)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        time         t;
    } exp_t;

    typedef struct {
        logic          wr;
        logic [2:0]    f3;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
        logic [31:0]   rdata;
        logic          fault;
    } vec_t;

    exp_t q1[$];
    exp_t q3[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (rv1) begin
            if (q1.size() == 0) begin
                chk("dut1 unexpected rsp_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("dut1 rdata", rd1, e.rdata);
                chk("dut1 fault", {31'b0, flt1}, {31'b0, e.fault});
                chk("dut1 latency", 32'($time - e.t), 32'd10);
            end
        end
        if (rv3) begin
            if (q3.size() == 0) begin
                chk("dut3 unexpected rsp_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q3.pop_front();
                chk("dut3 rdata", rd3, e.rdata);
                chk("dut3 fault", {31'b0, flt3}, {31'b0, e.fault});
                chk("dut3 latency", 32'($time - e.t), 32'd30);
            end
        end
    end

    task automatic issue1(input vec_t v, output int stall);
        stall = 0;
        v1 = 1'b1; w1 = v.wr; f1 = v.f3; a1 = v.addr; wd1 = v.wd;
        @(negedge clock);
        while (!rdy1 && stall < 20) begin
            stall++;
            @(negedge clock);
        end
        if (!rdy1) chk("dut1 ready timeout", 32'd0, 32'd1);
        else q1.push_back('{rdata: v.rdata, fault: v.fault, t: $time});
        @(posedge clock);
        #1;
    endtask

    task automatic issue3(input vec_t v, input bit push,
                          output int stall);
        stall = 0;
        v3 = 1'b1; w3 = v.wr; f3 = v.f3; a3 = v.addr; wd3 = v.wd;
        @(negedge clock);
        while (!rdy3 && stall < 20) begin
            stall++;
            @(negedge clock);
        end
        if (!rdy3) chk("dut3 ready timeout", 32'd0, 32'd1);
        else if (push)
            q3.push_back('{rdata: v.rdata, fault: v.fault, t: $time});
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q1.size() != 0 || q3.size() != 0) && n < 20) begin
            n++;
            @(negedge clock);
        end
        chk(name, 32'(q1.size() + q3.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    vec_t vt[23];
    vec_t hs[4];

    initial begin
        int st;
        int stalls;

        vt[0]  = '{1, F3_W,  10'h030, 32'hAAAAAAAA, 32'h0, 0};
        vt[1]  = '{1, F3_W,  10'h020, 32'h00000000, 32'h0, 0};
        vt[2]  = '{1, F3_W,  10'h010, 32'h12345678, 32'h0, 0};
        vt[3]  = '{0, F3_W,  10'h010, 32'h0, 32'h12345678, 0};
        vt[4]  = '{1, F3_B,  10'h013, 32'hFFFFFF80, 32'h0, 0};
        vt[5]  = '{0, F3_B,  10'h013, 32'h0, 32'hFFFFFF80, 0};
        vt[6]  = '{0, F3_BU, 10'h013, 32'h0, 32'h00000080, 0};
        vt[7]  = '{0, F3_W,  10'h010, 32'h0, 32'h80345678, 0};
        vt[8]  = '{1, F3_H,  10'h022, 32'h1234BEEF, 32'h0, 0};
        vt[9]  = '{0, F3_H,  10'h022, 32'h0, 32'hFFFFBEEF, 0};
        vt[10] = '{0, F3_HU, 10'h022, 32'h0, 32'h0000BEEF, 0};
        vt[11] = '{0, F3_W,  10'h020, 32'h0, 32'hBEEF0000, 0};
        vt[12] = '{1, F3_W,  10'h031, 32'h55555555, 32'h0, 1};
        vt[13] = '{0, F3_W,  10'h030, 32'h0, 32'hAAAAAAAA, 0};
        vt[14] = '{0, 3'b011, 10'h030, 32'h0, 32'h0, 1};
        vt[15] = '{1, F3_BU, 10'h030, 32'h00000011, 32'h0, 1};
        vt[16] = '{1, 3'b110, 10'h030, 32'h00000011, 32'h0, 1};
        vt[17] = '{0, F3_W,  10'h030, 32'h0, 32'hAAAAAAAA, 0};
        vt[18] = '{0, F3_H,  10'h021, 32'h0, 32'h0, 1};
        vt[19] = '{0, F3_W,  10'h022, 32'h0, 32'h0, 1};
        vt[20] = '{0, F3_BU, 10'h022, 32'h0, 32'h000000EF, 0};
        vt[21] = '{1, F3_H,  10'h010, 32'hFFFF7FFF, 32'h0, 0};
        vt[22] = '{0, F3_W,  10'h010, 32'h0, 32'h80347FFF, 0};

        hs[0] = '{1, F3_W, 10'h040, 32'h11111111, 32'h0, 0};
        hs[1] = '{0, F3_W, 10'h040, 32'h0, 32'h11111111, 0};
        hs[2] = '{1, F3_W, 10'h040, 32'h22222222, 32'h0, 0};
        hs[3] = '{0, F3_W, 10'h040, 32'h0, 32'h22222222, 0};

        reset1 = 1'b1; v1 = 1'b0; w1 = 1'b0;
        f1 = 3'b0; a1 = '0; wd1 = 32'h0;
        reset3 = 1'b1; v3 = 1'b0; w3 = 1'b0;
        f3 = 3'b0; a3 = '0; wd3 = 32'h0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset req_ready", {31'b0, rdy1}, 32'd0);
        chk("reset rsp_valid", {31'b0, rv1}, 32'd0);
        chk("reset rsp_rdata", rd1, 32'd0);
        chk("reset rsp_fault", {31'b0, flt1}, 32'd0);
        @(posedge clock);
        #1;
        reset1 = 1'b0;
        reset3 = 1'b0;
        @(negedge clock);
        chk("ready before first edge", {31'b0, rdy1}, 32'd0);
        @(negedge clock);
        chk("ready after reset", {31'b0, rdy1}, 32'd1);
        @(posedge clock);
        #1;

        stalls = 0;
        for (int i = 0; i < 23; i++) begin
            issue1(vt[i], st);
            stalls += st;
        end
        v1 = 1'b0;
        chk("dut1 back-to-back stalls", 32'(stalls), 32'd0);
        drain("dut1 drain");

        for (int i = 0; i < 4; i++) begin
            issue3(hs[i], 1'b1, st);
            if (i > 0) chk("dut3 ready low cycles", 32'(st), 32'd2);
        end
        v3 = 1'b0;
        drain("dut3 handshake drain");

        issue3('{1, F3_W, 10'h060, 32'hCAFEF00D, 32'h0, 0}, 1'b0, st);
        v3 = 1'b0;
        reset3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("mid-reset rsp_valid", {31'b0, rv3}, 32'd0);
            chk("mid-reset req_ready", {31'b0, rdy3}, 32'd0);
        end
        @(posedge clock);
        #1;
        reset3 = 1'b0;
        @(negedge clock);
        chk("post-reset ready early", {31'b0, rdy3}, 32'd0);
        @(negedge clock);
        chk("post-reset ready", {31'b0, rdy3}, 32'd1);
        @(posedge clock);
        #1;
        issue3('{0, F3_W, 10'h060, 32'h0, 32'hCAFEF00D, 0}, 1'b1, st);
        v3 = 1'b0;
        drain("dut3 reset drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
